// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: op encodings, sequencer states
// and a small helper used by both the slice and the sequencer.
package serial_alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Ops 4..7 are bitwise; ops 0..3 go through the adder (bit 0 selects subtract).
    function automatic logic is_logic_op(input logic [2:0] ctrl);
        return ctrl[2];
    endfunction

endpackage

// File: rtl/serial_alu_alu1.sv
// One-bit ALU slice. Arithmetic ops invert b when control[0] is set so that a
// carry-in of 1 turns the add into a two's-complement subtract. Logic ops
// never produce a carry.
module serial_alu_alu1
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carryin,
    input  logic [2:0] control,
    output logic       result,
    output logic       carryout
);

    logic b_eff;
    logic arith;

    // Combinational bit function selected by the op code.
    always_comb begin
        arith    = !is_logic_op(control);
        b_eff    = b ^ (control[0] & arith);
        result   = a ^ b_eff ^ carryin;
        carryout = 1'b0;
        case (control)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_XOR: result = a ^ b;
            default: carryout = (a & b_eff) | (a & carryin) | (b_eff & carryin);
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial WIDTH-bit ALU. Operands are shifted LSB first through a single
// alu1 slice, one bit per clock; the result is reassembled MSB-in and the
// flags are captured together with it on the final bit.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; out/flags hold the last result
// S_RUN  | one operand bit pair per clock through the slice
// S_DONE | done pulse; start here begins the next op immediately
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [2:0]       ctrl_q;
    logic             carry_ff;
    logic [CW-1:0]    bit_cnt;

    logic             slice_res;
    logic             slice_cout;
    logic             last_bit;
    logic [WIDTH-1:0] result_next;

    serial_alu_alu1 u_slice (
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .carryin  (carry_ff),
        .control  (ctrl_q),
        .result   (slice_res),
        .carryout (slice_cout)
    );

    assign last_bit    = (bit_cnt == CW'(WIDTH - 1));
    assign result_next = {slice_res, res_sh};

    // Sequencer, operand/result shifters and flag capture.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            ctrl_q   <= '0;
            carry_ff <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sh     <= A;
                        b_sh     <= B;
                        ctrl_q   <= control;
                        carry_ff <= control[0];
                        bit_cnt  <= '0;
                        state    <= S_RUN;
                        busy     <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    res_sh   <= result_next[WIDTH-1:1];
                    carry_ff <= slice_cout;
                    bit_cnt  <= bit_cnt + CW'(1);
                    if (last_bit) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        out      <= result_next;
                        zero     <= (result_next == '0);
                        negative <= slice_res;
                        // carry_ff is the carry into the MSB at this point.
                        overflow <= !is_logic_op(ctrl_q) & (carry_ff ^ slice_cout);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
module tb_serial_alu;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   control;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         overflow;
    logic         zero;
    logic         negative;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   ctrl;
        logic [W-1:0] r;
        logic         ov;
        logic         z;
        logic         n;
    } vec_t;

    vec_t vecs[12];

    always #5 clock = ~clock;

    serial_alu #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .A        (A),
        .B        (B),
        .control  (control),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic and sign rules for overflow.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                         output logic [W-1:0] r, output logic ov);
        ov = 1'b0;
        case (c)
            3'd0, 3'd2: begin
                r  = a + b;
                ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1, 3'd3: begin
                r  = a - b;
                ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd4:    r = a & b;
            3'd5:    r = a | b;
            3'd6:    r = ~(a | b);
            default: r = a ^ b;
        endcase
    endtask

    // Issue one op, scramble the inputs afterwards, wait for done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                          output logic [W-1:0] r, output logic ov, output logic z,
                          output logic n, output int lat);
        start   = 1'b1;
        A       = a;
        B       = b;
        control = c;
        step();
        start   = 1'b0;
        A       = $urandom;
        B       = $urandom;
        control = 3'($urandom);
        chk1("busy_in_run", busy, 1'b1);
        lat = 0;
        while (!done && lat < W + 10) begin
            step();
            lat++;
        end
        r  = out;
        ov = overflow;
        z  = zero;
        n  = negative;
        step();
        chk1("done_pulse_width", done, 1'b0);
        chk("out_hold_idle", out, r);
    endtask

    initial begin
        logic [W-1:0] r, er, ra, rb;
        logic         ov, z, n, eov;
        logic [2:0]   rc;
        int           lat;
        bit           seen;

        vecs[0]  = '{32'h7FFF_FFFF, 32'h0000_0001, 3'd2, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'h0000_0005, 32'h0000_0005, 3'd3, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h0000_0000, 32'h0000_0001, 3'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 32'hF000_F000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 3'd6, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{32'h0F0F_0000, 32'h0000_00F0, 3'd5, 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'hAAAA_AAAA, 32'hAAAA_AAAA, 3'd7, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'h0000_0001, 32'h0000_0002, 3'd0, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h0000_000A, 32'h0000_0003, 3'd1, 32'h0000_0007, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h8000_0000, 32'h0000_0001, 3'd3, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{32'h8000_0000, 32'h8000_0000, 3'd6, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};

        // Reset held with start asserted: nothing may move.
        reset   = 1'b0;
        start   = 1'b1;
        A       = 32'hFFFF_FFFF;
        B       = 32'h1;
        control = 3'd2;
        for (int i = 0; i < 2; i++) begin
            step();
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_done", done, 1'b0);
            chk("rst_out", out, '0);
            chk1("rst_ov", overflow, 1'b0);
            chk1("rst_zero", zero, 1'b0);
            chk1("rst_neg", negative, 1'b0);
        end
        reset = 1'b1;
        start = 1'b0;
        step();
        chk1("idle_busy", busy, 1'b0);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ctrl, r, ov, z, n, lat);
            chk("vec_latency", 32'(lat), 32'(W));
            chk("vec_out", r, vecs[i].r);
            chk1("vec_ov", ov, vecs[i].ov);
            chk1("vec_zero", z, vecs[i].z);
            chk1("vec_neg", n, vecs[i].n);
        end

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : 32'($urandom);
            rc = 3'($urandom);
            model(ra, rb, rc, er, eov);
            run_op(ra, rb, rc, r, ov, z, n, lat);
            chk("rnd_latency", 32'(lat), 32'(W));
            chk("rnd_out", r, er);
            chk1("rnd_ov", ov, eov);
            chk1("rnd_zero", z, (er == '0));
            chk1("rnd_neg", n, er[W-1]);
        end

        // start held high: back-to-back ops, A changed mid-run.
        start   = 1'b1;
        A       = 32'd100;
        B       = 32'd23;
        control = 3'd2;
        step();
        lat = 0;
        while (!done && lat < W + 10) begin
            step();
            lat++;
            if (lat == 3) A = 32'h1234_5678;
        end
        chk("b2b_first_latency", 32'(lat), 32'(W));
        chk("b2b_first_out", out, 32'd123);
        A       = 32'd7;
        B       = 32'd8;
        control = 3'd2;
        lat = 0;
        step();
        lat++;
        while (!done && lat < W + 10) begin
            step();
            lat++;
        end
        chk("b2b_period", 32'(lat), 32'(W + 1));
        chk("b2b_second_out", out, 32'd15);
        start = 1'b0;
        step();

        // Reset in the middle of a run: no done, outputs cleared.
        start   = 1'b1;
        A       = 32'd1;
        B       = 32'd2;
        control = 3'd2;
        step();
        start = 1'b0;
        repeat (10) step();
        chk1("midrst_busy_before", busy, 1'b1);
        reset = 1'b0;
        step();
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_done", done, 1'b0);
        chk("midrst_out", out, '0);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (W + 5) begin
            step();
            if (done) seen = 1'b1;
        end
        chk1("midrst_no_done", seen, 1'b0);
        run_op(32'd40, 32'd2, 3'd2, r, ov, z, n, lat);
        chk("after_rst_latency", 32'(lat), 32'(W));
        chk("after_rst_out", r, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
